// File: rtl/fp16_divider.sv
// Iterative FP16 divider: restoring division of the significands, one quotient bit per cycle.
// After an accept, IDLE spends one cycle classifying the captured operands before it picks DIV or DONE.
module fp16_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        div_zero,
    output logic        invalid,
    output logic        overflow,
    output logic        underflow
);

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

    state_t      state_q, state_d;
    logic        pend_q, pend_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [13:0] quo_q, quo_d;
    logic [11:0] rem_q, rem_d;
    logic [15:0] res_q, res_d;
    logic        dz_q, dz_d, inv_q, inv_d, ovf_q, ovf_d, unf_q, unf_d;

    // Operand decode; exponent zero is treated as zero (subnormals flushed)
    logic       sa, sb, sgn;
    logic [4:0] ea, eb;
    logic [9:0] ma, mb;
    logic       a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;

    assign sa     = a_q[15];
    assign sb     = b_q[15];
    assign ea     = a_q[14:10];
    assign eb     = b_q[14:10];
    assign ma     = a_q[9:0];
    assign mb     = b_q[9:0];
    assign sgn    = sa ^ sb;
    assign a_nan  = (&ea) & (|ma);
    assign a_inf  = (&ea) & ~(|ma);
    assign a_zero = ~(|ea);
    assign b_nan  = (&eb) & (|mb);
    assign b_inf  = (&eb) & ~(|mb);
    assign b_zero = ~(|eb);

    logic        spec_hit, spec_inv, spec_dz;
    logic [15:0] spec_res;

    always_comb begin
        spec_hit = 1'b1;
        spec_inv = 1'b0;
        spec_dz  = 1'b0;
        spec_res = 16'h0000;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res = 16'h7E00;
            spec_inv = 1'b1;
        end else if (a_inf) begin
            spec_res = {sgn, 5'h1F, 10'h000};
        end else if (b_zero) begin
            spec_res = {sgn, 5'h1F, 10'h000};
            spec_dz  = 1'b1;
        end else if (a_zero || b_inf) begin
            spec_res = {sgn, 15'h0000};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // One restoring step: remainder stays below the divisor, so the shift fits 12 bits
    logic [11:0] divisor, trial;
    logic        qbit;

    assign divisor = {1'b0, 1'b1, mb};
    assign qbit    = (rem_q >= divisor);
    assign trial   = qbit ? (rem_q - divisor) : rem_q;

    // Normalise, round to nearest even, range-check
    logic [9:0]        mant_t;
    logic              g_t, s_t, inc;
    logic [10:0]       mant_r;
    logic signed [6:0] e_t, e_r;
    logic [15:0]       norm_res;
    logic              norm_ovf, norm_unf;

    always_comb begin
        if (quo_q[13]) begin
            mant_t = quo_q[12:3];
            g_t    = quo_q[2];
            s_t    = (|quo_q[1:0]) | (|rem_q);
            e_t    = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 7'sd15;
        end else begin
            mant_t = quo_q[11:2];
            g_t    = quo_q[1];
            s_t    = quo_q[0] | (|rem_q);
            e_t    = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 7'sd14;
        end
        inc    = g_t & (s_t | mant_t[0]);
        mant_r = {1'b0, mant_t} + {10'h000, inc};
        e_r    = mant_r[10] ? (e_t + 7'sd1) : e_t;
        norm_ovf = 1'b0;
        norm_unf = 1'b0;
        if (e_r >= 7'sd31) begin
            norm_res = {sgn, 5'h1F, 10'h000};
            norm_ovf = 1'b1;
        end else if (e_r <= 7'sd0) begin
            norm_res = {sgn, 15'h0000};
            norm_unf = 1'b1;
        end else begin
            norm_res = {sgn, e_r[4:0], mant_r[10] ? 10'h000 : mant_r[9:0]};
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        res_d   = res_q;
        dz_d    = dz_q;
        inv_d   = inv_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    pend_d = 1'b0;
                    if (spec_hit) begin
                        res_d   = spec_res;
                        inv_d   = spec_inv;
                        dz_d    = spec_dz;
                        state_d = DONE;
                    end else begin
                        rem_d   = {1'b0, 1'b1, ma};
                        quo_d   = 14'h0000;
                        cnt_d   = 4'd0;
                        state_d = DIV;
                    end
                end else if (in_valid) begin
                    a_d    = A;
                    b_d    = B;
                    pend_d = 1'b1;
                    dz_d   = 1'b0;
                    inv_d  = 1'b0;
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
                end
            end
            DIV: begin
                quo_d = {quo_q[12:0], qbit};
                rem_d = {trial[10:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd13) state_d = NORM;
            end
            NORM: begin
                res_d   = norm_res;
                ovf_d   = norm_ovf;
                unf_d   = norm_unf;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            cnt_q   <= 4'd0;
            quo_q   <= 14'h0000;
            rem_q   <= 12'h000;
            res_q   <= 16'h0000;
            dz_q    <= 1'b0;
            inv_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
            inv_q   <= inv_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !pend_q;
    assign out_valid = (state_q == DONE);
    assign result    = res_q;
    assign div_zero  = dz_q;
    assign invalid   = inv_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule
